// File: rtl/sd_defines_pkg.sv
// Shared SD command-path definitions: response types, setting-word field
// positions, response sizes and host status bit indices.
package sd_defines_pkg;

  typedef enum logic [1:0] {
    RSP_NONE      = 2'd0,
    RSP_SHORT     = 2'd1,
    RSP_LONG      = 2'd2,
    RSP_SHORT_ALT = 2'd3
  } rsp_type_e;

  localparam int SET_SIZE_LSB = 0;
  localparam int SET_SIZE_W   = 7;
  localparam int SET_CRC_BIT  = 7;
  localparam int SET_DLY_LSB  = 8;
  localparam int SET_DLY_W    = 3;
  localparam int SET_WR_BIT   = 11;
  localparam int SET_RD_BIT   = 12;
  localparam int SET_WSEL_LSB = 13;

  localparam logic [6:0] RSP_SIZE_SHORT = 7'd40;
  localparam logic [6:0] RSP_SIZE_LONG  = 7'd127;

  localparam int STS_PHASE_LSB = 0;
  localparam int STS_PHASE_W   = 4;
  localparam int STS_CRC_OK    = 5;
  localparam int STS_DONE      = 6;

  // Type 3 is a legacy alias of the short response, so it shares the default arm.
  function automatic logic [15:0] encode_setting(
    input rsp_type_e  rspType,
    input logic       crcChk,
    input logic       blkWr,
    input logic       blkRd,
    input logic [1:0] wordSel,
    input logic [2:0] dlyWo
  );
    logic [15:0] s;
    s = '0;
    case (rspType)
      RSP_NONE: s[SET_DLY_LSB +: SET_DLY_W]   = dlyWo;
      RSP_LONG: s[SET_SIZE_LSB +: SET_SIZE_W] = RSP_SIZE_LONG;
      default:  s[SET_SIZE_LSB +: SET_SIZE_W] = RSP_SIZE_SHORT;
    endcase
    s[SET_CRC_BIT]       = crcChk;
    s[SET_WR_BIT]        = blkWr;
    s[SET_RD_BIT]        = blkRd;
    s[SET_WSEL_LSB +: 2] = wordSel;
    return s;
  endfunction

endpackage

// File: rtl/sd_cmd_master.sv
// SD command sequencer: issues one command to the serial host, services its
// status handshakes, and reports the response plus error flags with a done pulse.
module sd_cmd_master
  import sd_defines_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16,
  parameter logic [2:0]  DLY_WO    = 3'd2
) (
  input  logic                 SD_CLK_IN,
  input  logic                 RST_IN,
  input  logic                 cmd_start_i,
  input  logic [5:0]           cmd_index_i,
  input  logic [31:0]          cmd_arg_i,
  input  logic [1:0]           rsp_type_i,
  input  logic [1:0]           word_sel_i,
  input  logic                 crc_chk_i,
  input  logic                 idx_chk_i,
  input  logic                 blk_rd_i,
  input  logic                 blk_wr_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [39:0]          rsp_o,
  output logic [2:0]           err_o,
  output logic [15:0]          SETTING_OUT,
  output logic [39:0]          CMD_OUT,
  output logic                 REQ_OUT,
  input  logic                 ACK_IN,
  input  logic                 REQ_IN,
  input  logic [7:0]           STATUS_IN,
  input  logic [39:0]          RSP_IN,
  output logic                 ACK_OUT,
  output logic                 GO_IDLE_O
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_EXEC, ST_FINISH, ST_ABORT, ST_DONE
  } state_e;

  localparam logic [TIMEOUT_W-1:0] ABORT_LAST = TIMEOUT_W'(3);

  state_e               state_q, state_d;
  logic                 reqInDly_q;
  logic                 ackInter_q;
  logic [TIMEOUT_W-1:0] tmoCnt_q;
  logic [39:0]          cmd_q;
  logic [39:0]          rsp_q;
  logic [15:0]          setting_q;
  logic [2:0]           err_q;
  logic                 crcChk_q, idxChk_q, rspShort_q, rspAny_q;

  logic reqRise, tmoHit, startAcc, statusFinal, statusInter, enterAbort;
  logic unusedStatus;

  assign reqRise     = REQ_IN & ~reqInDly_q;
  assign tmoHit      = (timeout_i != '0) && (tmoCnt_q == timeout_i);
  assign startAcc    = (state_q == ST_IDLE) && cmd_start_i;
  assign statusFinal = (state_q == ST_EXEC) && reqRise && STATUS_IN[STS_DONE];
  assign statusInter = (state_q == ST_EXEC) && reqRise && !STATUS_IN[STS_DONE];
  // A status arriving on the match cycle takes priority over the abort.
  assign enterAbort  = (state_q == ST_EXEC) && !reqRise && tmoHit;

  assign unusedStatus = ^{STATUS_IN[7], STATUS_IN[4], STATUS_IN[STS_PHASE_LSB +: STS_PHASE_W]};

  assign CMD_OUT     = cmd_q;
  assign SETTING_OUT = setting_q;
  assign rsp_o       = rsp_q;
  assign err_o       = err_q;

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    REQ_OUT   = 1'b0;
    ACK_OUT   = ackInter_q;
    GO_IDLE_O = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (cmd_start_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        REQ_OUT = 1'b1;
        if (!ACK_IN) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (statusFinal)     state_d = ST_FINISH;
        else if (enterAbort) state_d = ST_ABORT;
      end
      ST_FINISH: begin
        ACK_OUT = 1'b1;
        if (ACK_IN) state_d = ST_DONE;
      end
      ST_ABORT: begin
        GO_IDLE_O = (tmoCnt_q == '0);
        if (tmoCnt_q == ABORT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) reqInDly_q <= 1'b0;
    else        reqInDly_q <= REQ_IN;
  end

  // The counter is reused in ABORT to time the GO_IDLE pulse and the wait after it.
  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      tmoCnt_q <= '0;
    end else if ((state_q == ST_ISSUE) || ((state_q == ST_EXEC) && reqRise) || enterAbort) begin
      tmoCnt_q <= '0;
    end else if (((state_q == ST_EXEC) || (state_q == ST_ABORT)) && (tmoCnt_q != '1)) begin
      tmoCnt_q <= tmoCnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      cmd_q      <= '0;
      setting_q  <= '0;
      rsp_q      <= '0;
      err_q      <= '0;
      crcChk_q   <= 1'b0;
      idxChk_q   <= 1'b0;
      rspShort_q <= 1'b0;
      rspAny_q   <= 1'b0;
      ackInter_q <= 1'b0;
    end else begin
      if (startAcc) begin
        cmd_q      <= {2'b01, cmd_index_i, cmd_arg_i};
        setting_q  <= encode_setting(rsp_type_e'(rsp_type_i), crc_chk_i, blk_wr_i,
                                     blk_rd_i, word_sel_i, DLY_WO);
        err_q      <= '0;
        crcChk_q   <= crc_chk_i;
        idxChk_q   <= idx_chk_i;
        rspShort_q <= rsp_type_i[0];
        rspAny_q   <= (rsp_type_i != 2'd0);
      end
      if (statusFinal) begin
        rsp_q    <= RSP_IN;
        err_q[2] <= idxChk_q & rspShort_q & (RSP_IN[37:32] != cmd_q[37:32]);
        err_q[1] <= crcChk_q & rspAny_q & ~STATUS_IN[STS_CRC_OK];
      end
      if (enterAbort) err_q[0] <= 1'b1;
      if (statusInter)                               ackInter_q <= 1'b1;
      else if (!REQ_IN || (state_q != ST_EXEC))      ackInter_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_cmd_master.sv
// Self-checking bench for sd_cmd_master: emulates the serial host handshake and
// compares encoding, response, error flags and pulse timing against a reference model.
module tb_sd_cmd_master;

  logic        clock;
  logic        reset;
  logic        cmd_start_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic [1:0]  rsp_type_i;
  logic [1:0]  word_sel_i;
  logic        crc_chk_i, idx_chk_i, blk_rd_i, blk_wr_i;
  logic [15:0] timeout_i;
  logic        busy_o, done_o;
  logic [39:0] rsp_o;
  logic [2:0]  err_o;
  logic [15:0] SETTING_OUT;
  logic [39:0] CMD_OUT;
  logic        REQ_OUT, ACK_IN, REQ_IN, ACK_OUT, GO_IDLE_O;
  logic [7:0]  STATUS_IN;
  logic [39:0] RSP_IN;

  int checks;
  int failures;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rspType;
    logic [1:0]  wordSel;
    logic        crcChk, idxChk, blkRd, blkWr;
    logic [15:0] timeout;
    int          numInter, firstGap, gap;
    logic        silent, crcOk;
    logic [39:0] rspIn;
    logic [15:0] expSetting;
    logic [39:0] expCmd;
    logic [2:0]  expErr;
  } vec_t;

  sd_cmd_master #(.TIMEOUT_W(16), .DLY_WO(3'd2)) dut (
    .SD_CLK_IN(clock), .RST_IN(reset),
    .cmd_start_i(cmd_start_i), .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i),
    .rsp_type_i(rsp_type_i), .word_sel_i(word_sel_i),
    .crc_chk_i(crc_chk_i), .idx_chk_i(idx_chk_i),
    .blk_rd_i(blk_rd_i), .blk_wr_i(blk_wr_i), .timeout_i(timeout_i),
    .busy_o(busy_o), .done_o(done_o), .rsp_o(rsp_o), .err_o(err_o),
    .SETTING_OUT(SETTING_OUT), .CMD_OUT(CMD_OUT), .REQ_OUT(REQ_OUT), .ACK_IN(ACK_IN),
    .REQ_IN(REQ_IN), .STATUS_IN(STATUS_IN), .RSP_IN(RSP_IN),
    .ACK_OUT(ACK_OUT), .GO_IDLE_O(GO_IDLE_O)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(
    input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] t, input logic [1:0] ws,
    input logic crc, input logic ic, input logic rd, input logic wr, input logic [15:0] tmo,
    input int nInter, input int firstGap, input int gap, input logic silent, input logic crcOk,
    input logic [39:0] rspIn, input logic [15:0] expSet, input logic [39:0] expCmd,
    input logic [2:0] expErr);
    vec_t v;
    v.idx = idx; v.arg = arg; v.rspType = t; v.wordSel = ws;
    v.crcChk = crc; v.idxChk = ic; v.blkRd = rd; v.blkWr = wr; v.timeout = tmo;
    v.numInter = nInter; v.firstGap = firstGap; v.gap = gap; v.silent = silent; v.crcOk = crcOk;
    v.rspIn = rspIn; v.expSetting = expSet; v.expCmd = expCmd; v.expErr = expErr;
    return v;
  endfunction

  // Reference model: field values computed arithmetically from the command description.
  function automatic logic [15:0] refSetting(input logic [1:0] t, input logic crc, input logic wr,
                                             input logic rd, input logic [1:0] ws);
    int size;
    int s;
    size = (t == 2'd0) ? 0 : (t == 2'd2) ? 127 : 40;
    s = size + 128 * int'(crc) + ((t == 2'd0) ? 2 * 256 : 0)
        + 2048 * int'(wr) + 4096 * int'(rd) + 8192 * int'(ws);
    return 16'(s);
  endfunction

  function automatic logic [39:0] refCmd(input logic [5:0] idx, input logic [31:0] arg);
    longint unsigned w;
    w = 64'h40_0000_0000 + 64'(idx) * 64'h1_0000_0000 + 64'(arg);
    return 40'(w);
  endfunction

  function automatic logic [2:0] refErr(input vec_t v);
    int idxBad;
    int crcBad;
    logic [5:0] rspIdx;
    if (v.silent) return 3'b001;
    rspIdx = v.rspIn[37:32];
    idxBad = (v.idxChk && (v.rspType == 2'd1 || v.rspType == 2'd3) && rspIdx != v.idx) ? 1 : 0;
    crcBad = (v.crcChk && v.rspType != 2'd0 && !v.crcOk) ? 1 : 0;
    return 3'(4 * idxBad + 2 * crcBad);
  endfunction

  task automatic applyStimulus(input vec_t v);
    int n;
    int gap;
    logic isFinal;
    cmd_index_i = v.idx; cmd_arg_i = v.arg; rsp_type_i = v.rspType; word_sel_i = v.wordSel;
    crc_chk_i = v.crcChk; idx_chk_i = v.idxChk; blk_rd_i = v.blkRd; blk_wr_i = v.blkWr;
    timeout_i = v.timeout;
    cmd_start_i = 1'b1;
    @(negedge clock);
    cmd_start_i = 1'b0;
    checkOutput("busy_cycle1", 64'(busy_o), 64'd1);
    checkOutput("req_cycle1", 64'(REQ_OUT), 64'd1);
    checkOutput("err_cleared", 64'(err_o), 64'd0);
    checkOutput("cmd_word", 64'(CMD_OUT), 64'(v.expCmd));
    checkOutput("setting_word", 64'(SETTING_OUT), 64'(v.expSetting));
    // A start strobe while busy must leave the latched command alone.
    cmd_index_i = ~v.idx;
    cmd_start_i = 1'b1;
    @(negedge clock);
    cmd_start_i = 1'b0;
    checkOutput("cmd_held_busy", 64'(CMD_OUT), 64'(v.expCmd));
    @(negedge clock);
    checkOutput("req_held", 64'(REQ_OUT), 64'd1);
    ACK_IN = 1'b0;
    @(negedge clock);
    checkOutput("req_dropped", 64'(REQ_OUT), 64'd0);
    if (v.silent) begin
      // Counter reads 0 on the first EXEC cycle and matches timeout_i on cycle timeout_i;
      // the abort pulse is visible the cycle after that.
      n = 0;
      while (!GO_IDLE_O && n < int'(v.timeout) + 10) begin
        @(negedge clock);
        n++;
      end
      checkOutput("abort_delay", 64'(n), 64'(int'(v.timeout) + 1));
      @(negedge clock);
      checkOutput("go_idle_width", 64'(GO_IDLE_O), 64'd0);
      ACK_IN = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("done_not_early", 64'(done_o), 64'd0);
    end else begin
      gap = v.firstGap;
      for (int k = 0; k <= v.numInter; k++) begin
        repeat (gap) @(negedge clock);
        isFinal = (k == v.numInter);
        REQ_IN = 1'b1;
        STATUS_IN = isFinal ? {1'b0, 1'b1, v.crcOk, 1'b0, 4'(k)} : {4'b0010, 4'(k)};
        RSP_IN = isFinal ? v.rspIn : {8'($urandom), $urandom};
        @(negedge clock);
        checkOutput(isFinal ? "final_ack" : "inter_ack", 64'(ACK_OUT), 64'd1);
        if (!isFinal) begin
          REQ_IN = 1'b0;
          @(negedge clock);
          checkOutput("inter_ack_release", 64'(ACK_OUT), 64'd0);
          gap = v.gap;
        end
      end
      REQ_IN = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("finish_ack_hold", 64'(ACK_OUT), 64'd1);
      checkOutput("busy_in_finish", 64'(busy_o), 64'd1);
      ACK_IN = 1'b1;
    end
    @(negedge clock);
    checkOutput("done_pulse", 64'(done_o), 64'd1);
    checkOutput("busy_at_done", 64'(busy_o), 64'd0);
    checkOutput("err_flags", 64'(err_o), 64'(v.expErr));
    if (!v.silent) begin
      checkOutput("rsp_word", 64'(rsp_o), 64'(v.rspIn));
      checkOutput("ack_released", 64'(ACK_OUT), 64'd0);
    end
    @(negedge clock);
    checkOutput("done_single", 64'(done_o), 64'd0);
    checkOutput("err_held", 64'(err_o), 64'(v.expErr));
  endtask

  initial begin
    vec_t dirVecs[$];
    vec_t v;
    logic [5:0] rIdx;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    cmd_start_i = 1'b0; cmd_index_i = '0; cmd_arg_i = '0; rsp_type_i = '0; word_sel_i = '0;
    crc_chk_i = 1'b0; idx_chk_i = 1'b0; blk_rd_i = 1'b0; blk_wr_i = 1'b0; timeout_i = '0;
    ACK_IN = 1'b1; REQ_IN = 1'b0; STATUS_IN = '0; RSP_IN = '0;

    //            idx    arg             t  ws crc ic rd wr tmo  nI fG gap sil ok rspIn              setting   cmd               err
    dirVecs.push_back(mk(6'd17, 32'h0000_1234, 2'd1, 2'd0, 1, 1, 0, 0, 16'd0,   1, 2, 3,  0, 1, 40'h11_0000_0900, 16'h00A8, 40'h51_0000_1234, 3'b000));
    dirVecs.push_back(mk(6'd0,  32'h0,         2'd0, 2'd0, 0, 0, 0, 0, 16'd0,   0, 4, 0,  0, 1, 40'h3F_0000_0000, 16'h0200, 40'h40_0000_0000, 3'b000));
    dirVecs.push_back(mk(6'd8,  32'h0000_01AA, 2'd1, 2'd0, 1, 0, 0, 0, 16'd0,   0, 1, 0,  0, 0, 40'h08_0000_01AA, 16'h00A8, 40'h48_0000_01AA, 3'b010));
    dirVecs.push_back(mk(6'd17, 32'hDEAD_BEEF, 2'd1, 2'd0, 1, 1, 0, 0, 16'd0,   0, 1, 0,  0, 1, 40'h03_1234_5678, 16'h00A8, 40'h51_DEAD_BEEF, 3'b100));
    dirVecs.push_back(mk(6'd2,  32'h0,         2'd2, 2'd3, 1, 1, 1, 0, 16'd0,   2, 3, 1,  0, 1, 40'h3F_0123_4567, 16'h70FF, 40'h42_0000_0000, 3'b000));
    dirVecs.push_back(mk(6'd5,  32'h0000_0055, 2'd3, 2'd1, 1, 1, 0, 1, 16'd0,   0, 2, 0,  0, 0, 40'h06_0000_0000, 16'h28A8, 40'h45_0000_0055, 3'b110));
    dirVecs.push_back(mk(6'h3F, 32'hFFFF_FFFF, 2'd0, 2'd0, 1, 1, 0, 0, 16'd0,   1, 0, 0,  0, 0, 40'h00_0000_0000, 16'h0280, 40'h7F_FFFF_FFFF, 3'b000));
    dirVecs.push_back(mk(6'd1,  32'h0,         2'd1, 2'd0, 0, 0, 0, 0, 16'd100, 0, 0, 0,  1, 0, 40'h0,             16'h0028, 40'h41_0000_0000, 3'b001));
    dirVecs.push_back(mk(6'd13, 32'h0001_0000, 2'd1, 2'd0, 1, 1, 0, 0, 16'd100, 2, 60, 60, 0, 1, 40'h0D_0000_0000, 16'h00A8, 40'h4D_0001_0000, 3'b000));
    // Status rise lands on the very cycle the counter matches: status must win.
    dirVecs.push_back(mk(6'd9,  32'h0,         2'd1, 2'd0, 0, 0, 0, 0, 16'd5,   1, 5, 0,  0, 1, 40'h09_0000_0000, 16'h0028, 40'h49_0000_0000, 3'b000));
    dirVecs.push_back(mk(6'd4,  32'h0000_0007, 2'd1, 2'd0, 0, 0, 0, 0, 16'd1,   0, 0, 0,  1, 0, 40'h0,             16'h0028, 40'h44_0000_0007, 3'b001));

    repeat (3) @(negedge clock);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_req", 64'(REQ_OUT), 64'd0);
    checkOutput("rst_ack", 64'(ACK_OUT), 64'd0);
    checkOutput("rst_go_idle", 64'(GO_IDLE_O), 64'd0);
    checkOutput("rst_rsp", 64'(rsp_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    checkOutput("rst_setting", 64'(SETTING_OUT), 64'd0);
    checkOutput("rst_cmd", 64'(CMD_OUT), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < dirVecs.size(); i++) applyStimulus(dirVecs[i]);

    for (int i = 0; i < 12; i++) begin
      rIdx = 6'($urandom);
      v = mk(rIdx, $urandom, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(150, 400)),
             $urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 20), 1'b0,
             1'($urandom), 40'h0, 16'h0, 40'h0, 3'b000);
      v.rspIn = {2'($urandom), ($urandom_range(0, 1) == 0) ? rIdx : 6'($urandom), $urandom};
      v.expSetting = refSetting(v.rspType, v.crcChk, v.blkWr, v.blkRd, v.wordSel);
      v.expCmd = refCmd(v.idx, v.arg);
      v.expErr = refErr(v);
      applyStimulus(v);
    end

    // Reset in the middle of EXEC while an intermediate acknowledge is active.
    cmd_index_i = 6'd17; cmd_arg_i = 32'h1234; rsp_type_i = 2'd1; timeout_i = '0;
    cmd_start_i = 1'b1;
    @(negedge clock);
    cmd_start_i = 1'b0;
    repeat (2) @(negedge clock);
    ACK_IN = 1'b0;
    @(negedge clock);
    REQ_IN = 1'b1;
    STATUS_IN = 8'h21;
    @(negedge clock);
    checkOutput("pre_reset_ack", 64'(ACK_OUT), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_ack", 64'(ACK_OUT), 64'd0);
    checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("async_rst_req", 64'(REQ_OUT), 64'd0);
    checkOutput("async_rst_done", 64'(done_o), 64'd0);
    checkOutput("async_rst_cmd", 64'(CMD_OUT), 64'd0);
    REQ_IN = 1'b0;
    ACK_IN = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rst_hold_done", 64'(done_o), 64'd0);
    reset = 1'b0;
    applyStimulus(dirVecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
